// File: rtl/idft_framer_pkg.sv
// Shared types and sizing helpers for the idft input framer.
package idft_framer_pkg;

   typedef enum logic [1:0] {
      Fill,
      Hold,
      Issue,
      Burst
   } state_e;

   localparam int unsigned SAMPLE_W_DEF = 16;

   typedef struct packed {
      logic [SAMPLE_W_DEF-1:0] re;
      logic [SAMPLE_W_DEF-1:0] im;
   } cplx_t;

   function automatic int unsigned beats(input int unsigned n);
      return n / 2;
   endfunction

   function automatic int unsigned ptr_w(input int unsigned n);
      return $clog2(n);
   endfunction

   function automatic int unsigned beat_w(input int unsigned n);
      return $clog2(n / 2);
   endfunction

   function automatic int unsigned gap_w(input int unsigned min_gap);
      return $clog2(min_gap + 1);
   endfunction

endpackage

// File: rtl/idft_in_framer_if.sv
// Serial complex-sample stream with valid/ready handshake.
interface idft_in_framer_if #(
   parameter int unsigned SAMPLE_W = 16
);
   logic                s_valid;
   logic                s_ready;
   logic [SAMPLE_W-1:0] s_re;
   logic [SAMPLE_W-1:0] s_im;

   modport master (output s_valid, output s_re, output s_im, input s_ready);
   modport slave  (input s_valid, input s_re, input s_im, output s_ready);
endinterface

// File: rtl/idft_frame_buf.sv
// One-frame complex sample store: one synchronous write port, two combinational read ports.
module idft_frame_buf #(
   parameter int unsigned N        = 64,
   parameter int unsigned SAMPLE_W = 16,
   localparam int unsigned PTR_W   = $clog2(N)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [PTR_W-1:0]    waddr,
   input  logic [SAMPLE_W-1:0] wre,
   input  logic [SAMPLE_W-1:0] wim,
   input  logic [PTR_W-1:0]    raddr_even,
   input  logic [PTR_W-1:0]    raddr_odd,
   output logic [SAMPLE_W-1:0] re_even,
   output logic [SAMPLE_W-1:0] im_even,
   output logic [SAMPLE_W-1:0] re_odd,
   output logic [SAMPLE_W-1:0] im_odd
);

   logic [SAMPLE_W-1:0] re_q [N];
   logic [SAMPLE_W-1:0] im_q [N];

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         re_q[waddr] <= wre;
         im_q[waddr] <= wim;
      end
   end

   assign re_even = re_q[raddr_even];
   assign im_even = im_q[raddr_even];
   assign re_odd  = re_q[raddr_odd];
   assign im_odd  = im_q[raddr_odd];

endmodule

// File: rtl/idft_in_framer.sv
// Buffers one frame of N complex samples, then pulses next and streams the frame
// as N/2 two-sample beats on X0..X3, keeping next pulses at least MIN_GAP cycles apart.
module idft_in_framer
   import idft_framer_pkg::*;
#(
   parameter int unsigned N        = 64,
   parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
   parameter int unsigned MIN_GAP  = 128
) (
   input  logic                clk,
   input  logic                rst,
   idft_in_framer_if.slave     s,
   output logic                next,
   output logic [SAMPLE_W-1:0] X0,
   output logic [SAMPLE_W-1:0] X1,
   output logic [SAMPLE_W-1:0] X2,
   output logic [SAMPLE_W-1:0] X3,
   output logic                busy,
   output logic [15:0]         frames_sent
);

   localparam int unsigned BEATS  = N / 2;
   localparam int unsigned PTR_W  = $clog2(N);
   localparam int unsigned BEAT_W = $clog2(N / 2);
   localparam int unsigned GAP_W  = $clog2(MIN_GAP + 1);

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [GAP_W-1:0]    gap_q, gap_d, gap_inc;
   logic [15:0]         frames_q, frames_d;
   logic                next_q, next_d;
   logic                busy_q, busy_d;
   logic [SAMPLE_W-1:0] x0_q, x1_q, x2_q, x3_q;
   logic [SAMPLE_W-1:0] x0_d, x1_d, x2_d, x3_d;
   logic                wr_en;
   logic [SAMPLE_W-1:0] re_even, im_even, re_odd, im_odd;

   idft_frame_buf #(
      .N        (N),
      .SAMPLE_W (SAMPLE_W)
   ) u_buf (
      .clk        (clk),
      .we         (wr_en),
      .waddr      (wr_ptr_q),
      .wre        (s.s_re),
      .wim        (s.s_im),
      .raddr_even ({beat_d, 1'b0}),
      .raddr_odd  ({beat_d, 1'b1}),
      .re_even    (re_even),
      .im_even    (im_even),
      .re_odd     (re_odd),
      .im_odd     (im_odd)
   );

   assign s.s_ready = (state_q == Fill);

   // gap_q counts cycles since the last next (0 in the Issue cycle), saturating at MIN_GAP.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      beat_d   = beat_q;
      frames_d = frames_q;
      wr_en    = 1'b0;
      gap_inc  = (gap_q == GAP_W'(MIN_GAP)) ? gap_q : gap_q + GAP_W'(1);
      gap_d    = gap_inc;

      unique case (state_q)
         Fill: begin
            if (s.s_valid) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
               if (wr_ptr_q == PTR_W'(N - 1)) state_d = Hold;
            end
         end
         Hold: begin
            if (gap_inc == GAP_W'(MIN_GAP)) begin
               state_d = Issue;
               gap_d   = '0;
            end
         end
         Issue: begin
            state_d  = Burst;
            beat_d   = '0;
            frames_d = frames_q + 16'd1;
         end
         Burst: begin
            if (beat_q == BEAT_W'(BEATS - 1)) begin
               state_d = Fill;
               beat_d  = '0;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         default: state_d = Fill;
      endcase
   end

   // Outputs are registered against the next state so they line up with state_q.
   always_comb begin
      next_d = (state_d == Issue);
      busy_d = (state_d != Fill);
      x0_d   = '0;
      x1_d   = '0;
      x2_d   = '0;
      x3_d   = '0;
      if (state_d == Burst) begin
         x0_d = re_even;
         x1_d = im_even;
         x2_d = re_odd;
         x3_d = im_odd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= Fill;
         wr_ptr_q <= '0;
         beat_q   <= '0;
         gap_q    <= GAP_W'(MIN_GAP);
         frames_q <= '0;
         next_q   <= 1'b0;
         busy_q   <= 1'b0;
         x0_q     <= '0;
         x1_q     <= '0;
         x2_q     <= '0;
         x3_q     <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         beat_q   <= beat_d;
         gap_q    <= gap_d;
         frames_q <= frames_d;
         next_q   <= next_d;
         busy_q   <= busy_d;
         x0_q     <= x0_d;
         x1_q     <= x1_d;
         x2_q     <= x2_d;
         x3_q     <= x3_d;
      end
   end

   assign next        = next_q;
   assign busy        = busy_q;
   assign frames_sent = frames_q;
   assign X0          = x0_q;
   assign X1          = x1_q;
   assign X2          = x2_q;
   assign X3          = x3_q;

endmodule

// File: doc/idft_in_framer.md
Name: idft_in_framer

Overview:
- Upstream feeder for the idft core.
- Accepts a serial stream of complex samples over a valid/ready interface and buffers one full frame of N samples.
- Then issues the core's single-cycle next pulse and streams the frame on X0..X3 as N/2 back-to-back beats of two complex samples each, which is the core's input convention.
- Enforces a minimum spacing between next pulses so the core is never re-triggered mid-computation.

Parameters:
- N, 64, complex samples per frame; even, power of two, >= 4.
- SAMPLE_W, 16, bits per real/imag component; matches X0..X3 width.
- MIN_GAP, 128, minimum clk cycles between consecutive next assertions; >= 1.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  framer can accept a sample.
- s_re  in  SAMPLE_W  sample real part.
- s_im  in  SAMPLE_W  sample imaginary part.
- next  out  1  one-cycle frame-start pulse to idft.
- X0  out  SAMPLE_W  real of even sample 2b.
- X1  out  SAMPLE_W  imag of even sample 2b.
- X2  out  SAMPLE_W  real of odd sample 2b+1.
- X3  out  SAMPLE_W  imag of odd sample 2b+1.
- busy  out  1  high in any state except FILL.
- frames_sent  out  16  count of next pulses issued; wraps at 2^16.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state=FILL, wr_ptr=0, beat=0, next=0, X0..X3=0, busy=0, frames_sent=0, gap_cnt=MIN_GAP (first frame is never delayed). Buffer contents are don't-care.
- All outputs are registered except s_ready. s_ready = (state==FILL), combinational from state.
- FILL:
  - A transfer occurs when s_valid && s_ready; the sample is written at wr_ptr and wr_ptr increments.
  - When the transfer at wr_ptr==N-1 occurs, the next state is HOLD and wr_ptr wraps to 0.
  - s_ready is therefore low from the cycle after the last sample.
- HOLD:
  - Buffer is full.
  - Transition to ISSUE when gap_cnt==MIN_GAP; otherwise remain in HOLD.
- ISSUE:
  - Lasts exactly 1 cycle, in which next=1 and X0..X3=0.
  - gap_cnt clears to 0 and frames_sent increments.
  - Next state is BURST with beat=0.
- BURST:
  - Lasts N/2 consecutive cycles, beat = 0..N/2-1.
  - X0/X1 = re/im of sample 2*beat; X2/X3 = re/im of sample 2*beat+1.
  - After beat N/2-1 the next state is FILL; X0..X3 return to 0 and s_ready=1 in that cycle.
- gap_cnt: increments by 1 every cycle except ISSUE, saturating at MIN_GAP.
- Latency:
  - Last sample accepted at cycle t → next at t+2 at the earliest (t+1 = HOLD).
  - First beat at t+3; last beat at t+2+N/2.
- X0..X3 are 0 in every cycle outside BURST.
- next is never high in two consecutive cycles, never within MIN_GAP cycles of the previous next, and never while a partial frame is buffered.
- Back-pressure:
  - s_valid may stay high while s_ready is low; no sample is consumed and no data is lost.
  - Upstream data need not be stable while s_ready is low.
- Sample index k maps to buffer address k; no reordering inside the framer (any bit-reversal is the core's concern).
- Reset mid-operation (any state, including mid-BURST): all state returns to reset values at once, the partial or full frame is discarded, and no further beats are emitted.
- Single buffer: no input is accepted during HOLD/ISSUE/BURST. Throughput is one frame per max(N+2+N/2, MIN_GAP) cycles.

Decomposition:
- Package idft_framer_pkg:
  - state enum: FILL, HOLD, ISSUE, BURST.
  - SAMPLE_W default.
  - Complex sample struct {re, im}.
  - Localparam helpers: BEATS=N/2, PTR_W=$clog2(N), BEAT_W=$clog2(N/2), GAP_W=$clog2(MIN_GAP+1).
- Sub-module idft_frame_buf:
  - Register-array memory of N complex samples, one synchronous write port.
  - Two combinational read ports (even/odd address).
  - Top level holds the FSM, counters and output registers.

Test Plan (N=8, MIN_GAP=12 unless noted):
- Reset then stream samples k=0..7 with re=k, im=0x100+k, s_valid held high → s_ready low from the cycle after k=7; next pulses 2 cycles after the k=7 transfer; 4 beats follow: (0,0x100,1,0x101), (2,0x102,3,0x103), (4,0x104,5,0x105), (6,0x106,7,0x107); then X=0 and s_ready=1; frames_sent=1.
- Random s_valid toggling (50%) over 3 frames → every sample appears exactly once, in order, in the correct X slot; frames_sent=3; no next within 12 cycles of the previous one.
- MIN_GAP=40, two frames fed at full rate → second next exactly 40 cycles after the first; framer sits in HOLD with s_ready=0 for the difference.
- s_valid high with garbage data during BURST → no writes occur; the next frame's content equals only samples presented while s_ready=1.
- Assert rst during beat 2 of a burst → next=0, X0..X3=0, busy=0, frames_sent=0 immediately; a fresh 8-sample frame afterwards is emitted correctly with no stale samples.
- Chain with the idft core (MIN_GAP=core frame spacing) → core next_out follows each framer next; Y0..Y3 match a reference model of the same input frame.
